// File: rtl/pp_accum_pkg.sv
// Shared types and widths for the partial-product accumulator sequencer.
// The widths are fixed by the customAdder37_14 datapath ports.
package pp_accum_pkg;

  localparam int OP_W  = 23;
  localparam int ACC_W = 37;
  localparam int CNT_W = 14;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/customAdder37_14.sv
// Combinational 37-bit + 23-bit unsigned adder with carry-out in Sum[37].
module customAdder37_14 (
  input  logic [36:0] A,
  input  logic [22:0] B,
  output logic [37:0] Sum
);

  assign Sum = {1'b0, A} + {15'b0, B};

endmodule

// File: rtl/pp_accum_ctrl.sv
// Accumulates a burst of unsigned partial products into a running sum,
// with a start handshake, an operand stream and a held result port.
module pp_accum_ctrl
  import pp_accum_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] start_count,
  input  logic [ACC_W-1:0] start_init,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic             res_ovf,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             ovf_reg, ovf_next;
  logic [SUM_W-1:0] adder_sum;

  customAdder37_14 u_adder (
    .A   (acc_reg),
    .B   (op_data),
    .Sum (adder_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      remaining_reg <= remaining_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    remaining_next = remaining_reg;
    ovf_next       = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          acc_next       = start_init;
          remaining_next = start_count;
          ovf_next       = 1'b0;
          state_next     = (start_count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (op_valid) begin
          acc_next       = adder_sum[ACC_W-1:0];
          ovf_next       = ovf_reg | adder_sum[ACC_W];
          remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        // acc/ovf are kept so the last result stays visible after hand-off.
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_ready = (state_reg == IDLE);
  assign op_ready    = (state_reg == ACCUM);
  assign res_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign res_sum     = acc_reg;
  assign res_ovf     = ovf_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(state_reg == ACCUM && remaining_reg == '0));
      assert ($countones({start_ready, op_ready, res_valid}) <= 1);
    end
  end

endmodule

// File: tb/tb_pp_accum_ctrl.sv
// Directed, table-driven bench for pp_accum_ctrl plus hand-written corner sequences.
module tb_pp_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [13:0] start_count = '0;
  logic [36:0] start_init = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [22:0] op_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [36:0] res_sum;
  logic        res_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pp_accum_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_count (start_count),
    .start_init  (start_init),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_data     (op_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [36:0]      init;
    int               count;
    logic [3:0][22:0] ops;
    logic [3:0][2:0]  gaps;
    logic [36:0]      exp_sum;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [36:0] init, input int count);
    chk("start_ready_idle", 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    start_init  = init;
    start_count = 14'(count);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic feed(input logic [22:0] data, input int gap);
    for (int g = 0; g < gap; g++) begin
      chk("op_ready_gap", 64'(op_ready), 64'd1);
      @(negedge clk);
    end
    op_valid = 1'b1;
    op_data  = data;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic finish_result(input logic [36:0] exp_sum, input logic exp_ovf);
    chk("res_valid_latency", 64'(res_valid), 64'd1);
    chk("res_sum", 64'(res_sum), 64'(exp_sum));
    chk("res_ovf", 64'(res_ovf), 64'(exp_ovf));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", 64'(res_valid), 64'd0);
    chk("res_sum_retained", 64'(res_sum), 64'(exp_sum));
  endtask

  initial begin
    vecs[0] = '{init: 37'h0, count: 3, ops: {23'h0, 23'h000001, 23'h7FFFFF, 23'h000005},
                gaps: '0, exp_sum: 37'h0000800005, exp_ovf: 1'b0};
    vecs[1] = '{init: 37'h1FFFFFFFFF, count: 2, ops: {23'h0, 23'h0, 23'h2, 23'h1},
                gaps: '0, exp_sum: 37'h2, exp_ovf: 1'b1};
    vecs[2] = '{init: 37'h0, count: 1, ops: {23'h0, 23'h0, 23'h0, 23'h7},
                gaps: '0, exp_sum: 37'h7, exp_ovf: 1'b0};
    vecs[3] = '{init: 37'h10, count: 4, ops: {23'h000001, 23'h7FFFFF, 23'h000200, 23'h000100},
                gaps: {3'd0, 3'd5, 3'd2, 3'd0}, exp_sum: 37'h0000800310, exp_ovf: 1'b0};
    vecs[4] = '{init: 37'h0FFFFFFFFF, count: 2, ops: {23'h0, 23'h0, 23'h7FFFFF, 23'h7FFFFF},
                gaps: '0, exp_sum: 37'h1000FFFFFD, exp_ovf: 1'b0};

    // Reset values, both while held and after release.
    #2;
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_sum", 64'(res_sum), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_start_ready", 64'(start_ready), 64'd1);
    chk("idle_res_valid", 64'(res_valid), 64'd0);
    chk("idle_res_sum", 64'(res_sum), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].init, vecs[v].count);
      chk("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < vecs[v].count; i++) begin
        if (i == vecs[v].count - 1) chk("res_valid_early", 64'(res_valid), 64'd0);
        feed(vecs[v].ops[i], int'(vecs[v].gaps[i]));
      end
      finish_result(vecs[v].exp_sum, vecs[v].exp_ovf);
      $display("vector %0d: count=%0d sum=0x%0h ovf=%0d", v, vecs[v].count, res_sum, res_ovf);
    end

    // Count-0 job under backpressure; stray operands must not be consumed.
    do_start(37'h1234, 0);
    chk("cnt0_res_valid", 64'(res_valid), 64'd1);
    chk("cnt0_op_ready", 64'(op_ready), 64'd0);
    op_valid = 1'b1;
    op_data  = 23'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_sum", 64'(res_sum), 64'h1234);
      chk("hold_op_ready", 64'(op_ready), 64'd0);
    end
    op_valid = 1'b0;
    finish_result(37'h1234, 1'b0);
    $display("count-0 job: sum=0x%0h", res_sum);

    // start_valid pulsed while accumulating is ignored.
    do_start(37'h0, 2);
    feed(23'h3, 0);
    start_valid = 1'b1;
    start_init  = 37'hABC;
    start_count = 14'd0;
    @(negedge clk);
    start_valid = 1'b0;
    chk("ign_start_op_ready", 64'(op_ready), 64'd1);
    chk("ign_start_res_valid", 64'(res_valid), 64'd0);
    feed(23'h4, 0);
    finish_result(37'h7, 1'b0);
    $display("ignored-start job: sum=0x%0h", res_sum);

    // Asynchronous reset after 2 of 4 operands aborts the job.
    do_start(37'h55, 4);
    feed(23'h10, 0);
    feed(23'h20, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_start_ready", 64'(start_ready), 64'd1);
    chk("abort_op_ready", 64'(op_ready), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_res_sum", 64'(res_sum), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(37'h0, 1);
    feed(23'h9, 0);
    finish_result(37'h9, 1'b0);
    $display("post-abort job: sum=0x%0h", res_sum);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
